// File: rtl/time_param_timer.sv
// time_param_timer: programmable duration store with an integrated 1 Hz countdown.
// Slots hold per-phase durations for the light-sequencing FSM. The selected
// duration is served on a registered output, and the same selection can be
// loaded into a countdown that pulses `expired` when it finishes.
module time_param_timer #(
    parameter int TW      = 4,
    parameter int NSLOT   = 4,
    parameter int DEF0    = 6,
    parameter int DEF1    = 3,
    parameter int DEF2    = 2,
    parameter int DEF_AUX = 0,
    parameter int SW      = $clog2(NSLOT + 1)
) (
    input  logic          clk,
    input  logic          Reset_Sync,
    input  logic          Prog_Sync,
    input  logic [SW-1:0] Selector,
    input  logic [TW-1:0] Time_value,
    output logic          prog_ack,
    input  logic [SW-1:0] interval,
    output logic [TW:0]   value,
    input  logic          Start_Timer,
    input  logic          tick_1hz,
    output logic [TW:0]   remaining,
    output logic          busy,
    output logic          expired
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [TW:0] ONE_W = (TW + 1)'(1);

    logic [TW-1:0] slot_q [NSLOT];
    logic [TW:0]   sel_s;
    logic [TW:0]   value_q;
    logic [TW:0]   remaining_q;
    logic          prog_ack_q;
    logic          busy_q;
    logic          expired_q;
    state_t        state_q;

    // Reset/default content of slot idx (base, extended, yellow, auxiliary).
    function automatic logic [TW-1:0] def_slot(input int idx);
        logic [TW-1:0] d;
        if (idx == 0) begin
            d = TW'(DEF0);
        end else if (idx == 1) begin
            d = TW'(DEF1);
        end else if (idx == 2) begin
            d = TW'(DEF2);
        end else begin
            d = TW'(DEF_AUX);
        end
        return d;
    endfunction

    // Duration lookup; the extra MSB keeps the doubled base value untruncated.
    always_comb begin
        sel_s = '0;
        if (interval == SW'(NSLOT)) begin
            sel_s = {slot_q[0], 1'b0};
        end else begin
            for (int i = 0; i < NSLOT; i++) begin
                if (interval == SW'(i)) begin
                    sel_s = {1'b0, slot_q[i]};
                end else begin
                    sel_s = sel_s;
                end
            end
        end
    end

    // Slot storage: restore-all on selector 0, single-slot write on 1..NSLOT.
    always_ff @(posedge clk) begin
        if (Reset_Sync) begin
            for (int i = 0; i < NSLOT; i++) begin
                slot_q[i] <= def_slot(i);
            end
        end else if (Prog_Sync) begin
            if (Selector == '0) begin
                for (int i = 0; i < NSLOT; i++) begin
                    slot_q[i] <= def_slot(i);
                end
            end else begin
                for (int i = 0; i < NSLOT; i++) begin
                    if (Selector == SW'(i + 1)) begin
                        slot_q[i] <= Time_value;
                    end
                end
            end
        end
    end

    // Registered duration read (sees pre-write contents) and program acknowledge.
    always_ff @(posedge clk) begin
        if (Reset_Sync) begin
            value_q    <= '0;
            prog_ack_q <= 1'b0;
        end else begin
            value_q    <= sel_s;
            prog_ack_q <= Prog_Sync;
        end
    end

    // Countdown FSM; a start strobe overrides any tick and reloads from any state.
    always_ff @(posedge clk) begin
        if (Reset_Sync) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            expired_q   <= 1'b0;
        end else if (Start_Timer) begin
            remaining_q <= sel_s;
            if (sel_s == '0) begin
                state_q   <= ST_DONE;
                busy_q    <= 1'b0;
                expired_q <= 1'b1;
            end else begin
                state_q   <= ST_COUNT;
                busy_q    <= 1'b1;
                expired_q <= 1'b0;
            end
        end else begin
            case (state_q)
                ST_COUNT: begin
                    if (tick_1hz) begin
                        // Values of 0 cannot occur in COUNT; treating them as
                        // the final step keeps the counter from wrapping.
                        if ((remaining_q == ONE_W) || (remaining_q == '0)) begin
                            remaining_q <= '0;
                            state_q     <= ST_DONE;
                            busy_q      <= 1'b0;
                            expired_q   <= 1'b1;
                        end else begin
                            remaining_q <= remaining_q - ONE_W;
                        end
                    end
                end
                ST_DONE: begin
                    remaining_q <= '0;
                    state_q     <= ST_IDLE;
                    busy_q      <= 1'b0;
                    expired_q   <= 1'b0;
                end
                ST_IDLE: begin
                    busy_q    <= 1'b0;
                    expired_q <= 1'b0;
                end
                default: begin
                    remaining_q <= '0;
                    state_q     <= ST_IDLE;
                    busy_q      <= 1'b0;
                    expired_q   <= 1'b0;
                end
            endcase
        end
    end

    assign value     = value_q;
    assign prog_ack  = prog_ack_q;
    assign remaining = remaining_q;
    assign busy      = busy_q;
    assign expired   = expired_q;

endmodule
